// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU instruction sequencer: state encoding, opcodes and mode decode.
package alu_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_RD_A  = 4'd1,
      S_LD_A  = 4'd2,
      S_RD_B  = 4'd3,
      S_LD_B  = 4'd4,
      S_LATCH = 4'd5,
      S_WB    = 4'd6,
      S_DONE  = 4'd7,
      S_ERR   = 4'd8
   } state_t;

   localparam logic [3:0] OPC_ALUI0 = 4'h0;
   localparam logic [3:0] OPC_ALUI1 = 4'h1;
   localparam logic [3:0] OPC_ALUR0 = 4'h2;
   localparam logic [3:0] OPC_ALUR1 = 4'h3;

   function automatic logic opc_is_imm(input logic [3:0] op);
      return (op == OPC_ALUI0) || (op == OPC_ALUI1);
   endfunction

   function automatic logic opc_is_reg(input logic [3:0] op);
      return (op == OPC_ALUR0) || (op == OPC_ALUR1);
   endfunction

   function automatic logic opc_valid(input logic [3:0] op);
      return opc_is_imm(op) || opc_is_reg(op);
   endfunction

endpackage

// File: rtl/alu_ctrl_fsm_if.sv
// Decoder-side handshake plus bus/ALU control strobes of the ALU instruction sequencer.
interface alu_ctrl_fsm_if #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 6,
   parameter int FIELD_W  = 6
);
   logic [4+2*FIELD_W-1:0] instruction;
   logic                   start;
   logic                   busy;
   logic                   done;
   logic                   illegal;
   logic                   pc_inc;
   logic [NUM_REGS-1:0]    rx_out;
   logic [NUM_REGS-1:0]    rx_in;
   logic                   alu_in0;
   logic                   alu_in1;
   logic                   alu_out_latch;
   logic                   alu_out_en;
   logic                   imm_out_en;
   logic [DATA_W-1:0]      imm_out;

   modport master (
      input  instruction, start,
      output busy, done, illegal, pc_inc, rx_out, rx_in,
             alu_in0, alu_in1, alu_out_latch, alu_out_en, imm_out_en, imm_out
   );

   modport slave (
      output instruction, start,
      input  busy, done, illegal, pc_inc, rx_out, rx_in,
             alu_in0, alu_in1, alu_out_latch, alu_out_en, imm_out_en, imm_out
   );
endinterface

// File: rtl/alu_ctrl_fsm_onehot_dec.sv
// Register index to one-hot enable; register 0 maps to the MSB, out-of-range gives all zeros.
module onehot_dec #(
   parameter int FIELD_W  = 6,
   parameter int NUM_REGS = 6
) (
   input  logic [FIELD_W-1:0]  idx,
   output logic [NUM_REGS-1:0] oh
);
   always_comb begin
      oh = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (32'(idx) == i) oh[NUM_REGS-1-i] = 1'b1;
      end
   end
endmodule

// File: rtl/alu_ctrl_fsm.sv
// Sequences one ALU instruction (immediate or register mode) over the shared data bus.
module alu_ctrl_fsm
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 6,
   parameter int FIELD_W  = 6
) (
   input  logic            clk,
   input  logic            rst,
   alu_ctrl_fsm_if.master  bus
);
   localparam int INSTR_W = 4 + 2*FIELD_W;

   state_t               state_q, state_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic [3:0]           op_in;
   logic [FIELD_W-1:0]   p1_in, p2_in, p1_q, p2_q;
   logic                 imm_q, bad_idx;
   logic [NUM_REGS-1:0]  oh_p1, oh_p2;
   logic [NUM_REGS-1:0]  rx_out, rx_in;
   logic                 busy, done, illegal, pc_inc;
   logic                 alu_in0, alu_in1, alu_out_latch, alu_out_en, imm_out_en;

   assign op_in = bus.instruction[INSTR_W-1 -: 4];
   assign p1_in = bus.instruction[2*FIELD_W-1 -: FIELD_W];
   assign p2_in = bus.instruction[FIELD_W-1:0];
   assign p1_q  = instr_q[2*FIELD_W-1 -: FIELD_W];
   assign p2_q  = instr_q[FIELD_W-1:0];
   assign imm_q = opc_is_imm(instr_q[INSTR_W-1 -: 4]);

   // p2 is only a register index in register mode; as an immediate it may take any value
   assign bad_idx = (int'(p1_in) >= NUM_REGS) ||
                    (opc_is_reg(op_in) && (int'(p2_in) >= NUM_REGS));

   onehot_dec #(.FIELD_W(FIELD_W), .NUM_REGS(NUM_REGS)) u_dec_p1 (.idx(p1_q), .oh(oh_p1));
   onehot_dec #(.FIELD_W(FIELD_W), .NUM_REGS(NUM_REGS)) u_dec_p2 (.idx(p2_q), .oh(oh_p2));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      instr_d       = instr_q;
      rx_out        = '0;
      rx_in         = '0;
      done          = 1'b0;
      illegal       = 1'b0;
      pc_inc        = 1'b0;
      alu_in0       = 1'b0;
      alu_in1       = 1'b0;
      alu_out_latch = 1'b0;
      alu_out_en    = 1'b0;
      imm_out_en    = 1'b0;
      busy          = (state_q != S_IDLE);
      case (state_q)
         S_IDLE: begin
            if (bus.start && opc_valid(op_in)) begin
               instr_d = bus.instruction;
               state_d = bad_idx ? S_ERR : S_RD_A;
            end
         end
         S_RD_A: begin
            rx_out  = oh_p1;
            pc_inc  = 1'b1;
            state_d = S_LD_A;
         end
         S_LD_A: begin
            rx_out  = oh_p1;
            alu_in0 = 1'b1;
            state_d = S_RD_B;
         end
         S_RD_B, S_LD_B: begin
            if (imm_q) imm_out_en = 1'b1;
            else       rx_out     = oh_p2;
            alu_in1 = (state_q == S_LD_B);
            state_d = (state_q == S_LD_B) ? S_LATCH : S_LD_B;
         end
         S_LATCH: begin
            alu_out_latch = 1'b1;
            state_d       = S_WB;
         end
         S_WB: begin
            alu_out_en = 1'b1;
            rx_in      = oh_p1;
            state_d    = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         S_ERR: begin
            done    = 1'b1;
            illegal = 1'b1;
            pc_inc  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.busy          = busy;
   assign bus.done          = done;
   assign bus.illegal       = illegal;
   assign bus.pc_inc        = pc_inc;
   assign bus.rx_out        = rx_out;
   assign bus.rx_in         = rx_in;
   assign bus.alu_in0       = alu_in0;
   assign bus.alu_in1       = alu_in1;
   assign bus.alu_out_latch = alu_out_latch;
   assign bus.alu_out_en    = alu_out_en;
   assign bus.imm_out_en    = imm_out_en;
   assign bus.imm_out       = imm_out_en ? DATA_W'(p2_q) : '0;
endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Self-checking bench for alu_ctrl_fsm: constant vectors, corner sequences and a random run vs a schedule model.
module tb_alu_ctrl_fsm;
   localparam int DW = 16;
   localparam int NR = 6;
   localparam int FW = 6;
   localparam int PW = 9 + 2*NR + DW;

   localparam logic [8:0] F_BUSY = 9'h100, F_DONE = 9'h080, F_ILL = 9'h040, F_PC  = 9'h020,
                          F_IN0  = 9'h010, F_IN1  = 9'h008, F_LAT = 9'h004, F_OEN = 9'h002,
                          F_IMM  = 9'h001;

   typedef logic [PW-1:0] pk_t;
   typedef struct {
      logic [15:0]    instr;
      int             k;
      logic [8:0]     f;
      logic [NR-1:0]  ro;
      logic [NR-1:0]  ri;
      logic [DW-1:0]  im;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   int          m_ph  = 0;
   logic [15:0] m_cap = '0;
   bit          m_err = 1'b0;

   alu_ctrl_fsm_if #(.DATA_W(DW), .NUM_REGS(NR), .FIELD_W(FW)) bus ();
   alu_ctrl_fsm #(.DATA_W(DW), .NUM_REGS(NR), .FIELD_W(FW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [NR-1:0] oh(input int i);
      logic [NR-1:0] r = '0;
      if (i < NR) r[NR-1-i] = 1'b1;
      return r;
   endfunction

   // Expected outputs from the instruction's position in its 7-cycle schedule (0 = idle)
   function automatic pk_t exp_pk(input int ph, input logic [15:0] c, input bit e);
      logic [8:0]    f  = '0;
      logic [NR-1:0] ro = '0;
      logic [NR-1:0] ri = '0;
      logic [DW-1:0] im = '0;
      int p1 = int'(c[11:6]);
      int p2 = int'(c[5:0]);
      bit imm = (c[15:12] < 4'd2);
      if (ph != 0) f |= F_BUSY;
      if (e && ph == 1) f |= F_DONE | F_ILL | F_PC;
      else begin
         case (ph)
            1: begin ro = oh(p1); f |= F_PC;  end
            2: begin ro = oh(p1); f |= F_IN0; end
            3, 4: begin
               if (imm) begin f |= F_IMM; im = DW'(p2); end
               else ro = oh(p2);
               if (ph == 4) f |= F_IN1;
            end
            5: f |= F_LAT;
            6: begin f |= F_OEN; ri = oh(p1); end
            7: f |= F_DONE;
            default: ;
         endcase
      end
      return {f, ro, ri, im};
   endfunction

   function automatic pk_t dut_pk();
      return {bus.busy, bus.done, bus.illegal, bus.pc_inc, bus.alu_in0, bus.alu_in1,
              bus.alu_out_latch, bus.alu_out_en, bus.imm_out_en,
              bus.rx_out, bus.rx_in, bus.imm_out};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic model_update();
      logic [3:0] op;
      if (rst) begin
         m_ph  = 0;
         m_cap = '0;
         m_err = 1'b0;
      end else if (m_ph == 0) begin
         op = bus.instruction[15:12];
         if (bus.start && op <= 4'd3) begin
            m_cap = bus.instruction;
            m_err = (int'(m_cap[11:6]) >= NR) || (op >= 4'd2 && int'(m_cap[5:0]) >= NR);
            m_ph  = 1;
         end
      end else if (m_err || m_ph == 7) m_ph = 0;
      else m_ph++;
   endtask

   task automatic tick();
      int ndrv;
      @(posedge clk);
      model_update();
      @(negedge clk);
      chk("model", 64'(dut_pk()), 64'(exp_pk(m_ph, m_cap, m_err)));
      ndrv = int'(|bus.rx_out) + int'(bus.imm_out_en) + int'(bus.alu_out_en);
      total++;
      if (ndrv > 1) begin
         bad++;
         $display("FAIL bus_excl: got %0d drivers want <=1 (t=%0t)", ndrv, $time);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.start = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   vec_t vt[$];
   int   t_done0, t_done1, n_pc;

   initial begin
      rst = 1'b1;
      bus.start = 1'b0;
      bus.instruction = '0;

      vt.push_back('{16'h0045, 1, F_BUSY|F_PC,  6'b010000, 6'b000000, 16'h0000});
      vt.push_back('{16'h0045, 2, F_BUSY|F_IN0, 6'b010000, 6'b000000, 16'h0000});
      vt.push_back('{16'h0045, 3, F_BUSY|F_IMM, 6'b000000, 6'b000000, 16'h0005});
      vt.push_back('{16'h0045, 4, F_BUSY|F_IN1|F_IMM, 6'b000000, 6'b000000, 16'h0005});
      vt.push_back('{16'h0045, 5, F_BUSY|F_LAT, 6'b000000, 6'b000000, 16'h0000});
      vt.push_back('{16'h0045, 6, F_BUSY|F_OEN, 6'b000000, 6'b010000, 16'h0000});
      vt.push_back('{16'h0045, 7, F_BUSY|F_DONE, 6'b000000, 6'b000000, 16'h0000});
      vt.push_back('{16'h0045, 8, 9'h000, 6'b000000, 6'b000000, 16'h0000});
      vt.push_back('{16'h2083, 3, F_BUSY, 6'b000100, 6'b000000, 16'h0000});
      vt.push_back('{16'h2083, 4, F_BUSY|F_IN1, 6'b000100, 6'b000000, 16'h0000});
      vt.push_back('{16'h2083, 6, F_BUSY|F_OEN, 6'b000000, 6'b001000, 16'h0000});
      vt.push_back('{16'h2007, 1, F_BUSY|F_DONE|F_ILL|F_PC, 6'b000000, 6'b000000, 16'h0000});
      vt.push_back('{16'h2007, 2, 9'h000, 6'b000000, 6'b000000, 16'h0000});
      vt.push_back('{16'h1145, 6, F_BUSY|F_OEN, 6'b000000, 6'b000001, 16'h0000});
      vt.push_back('{16'h3186, 1, F_BUSY|F_DONE|F_ILL|F_PC, 6'b000000, 6'b000000, 16'h0000});
      vt.push_back('{16'h01C0, 1, F_BUSY|F_DONE|F_ILL|F_PC, 6'b000000, 6'b000000, 16'h0000});
      vt.push_back('{16'h003F, 3, F_BUSY|F_IMM, 6'b000000, 6'b000000, 16'h003F});
      vt.push_back('{16'h2145, 3, F_BUSY, 6'b000001, 6'b000000, 16'h0000});

      // Reset and idle
      do_reset();
      chk("reset_zero", 64'(dut_pk()), 64'd0);
      tick();
      chk("idle_zero", 64'(dut_pk()), 64'd0);

      foreach (vt[i]) begin
         do_reset();
         bus.instruction = vt[i].instr;
         bus.start = 1'b1;
         tick();
         bus.start = 1'b0;
         bus.instruction = 16'($urandom);
         repeat (vt[i].k - 1) tick();
         chk($sformatf("vec%0d_%h_k%0d", i, vt[i].instr, vt[i].k), 64'(dut_pk()),
             64'({vt[i].f, vt[i].ro, vt[i].ri, vt[i].im}));
         repeat (9 - vt[i].k) tick();
      end

      // Reset during LATCH aborts with no write-back
      do_reset();
      bus.instruction = 16'h0045;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (4) tick();
      chk("latch_state", 64'(dut_pk()), 64'(PW'({F_BUSY|F_LAT, {(2*NR+DW){1'b0}}})));
      rst = 1'b1;
      tick();
      chk("abort_zero", 64'(dut_pk()), 64'd0);
      rst = 1'b0;
      repeat (3) tick();
      chk("abort_no_wb", 64'(dut_pk()), 64'd0);

      // Undefined opcode is ignored even with start held
      do_reset();
      bus.instruction = 16'h5045;
      bus.start = 1'b1;
      tick();
      chk("bad_op_busy", 64'(bus.busy), 64'd0);
      tick();
      chk("bad_op_busy2", 64'(bus.busy), 64'd0);
      bus.start = 1'b0;

      // Instruction changed after capture: captured value wins
      bus.instruction = 16'h0045;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.instruction = 16'h2083;
      repeat (5) tick();
      chk("captured_rx_in", 64'(bus.rx_in), 64'(6'b010000));
      repeat (3) tick();

      // start held high: back-to-back instructions
      do_reset();
      bus.instruction = 16'h0045;
      bus.start = 1'b1;
      t_done0 = -1;
      t_done1 = -1;
      n_pc = 0;
      for (int t = 1; t <= 16; t++) begin
         tick();
         bus.instruction = 16'h2083;
         if (bus.pc_inc) n_pc++;
         if (bus.done) begin
            if (t_done0 < 0) t_done0 = t;
            else t_done1 = t;
         end
      end
      bus.start = 1'b0;
      chk("b2b_done0", 64'(t_done0), 64'd7);
      chk("b2b_done_gap", 64'(t_done1 - t_done0), 64'd8);
      chk("b2b_pc_inc", 64'(n_pc), 64'd2);
      repeat (2) tick();

      // Random traffic against the schedule model
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 99) == 0);
         bus.start = ($urandom_range(0, 9) < 4);
         bus.instruction[15:12] = ($urandom_range(0, 4) == 4) ? 4'($urandom_range(4, 15))
                                                              : 4'($urandom_range(0, 3));
         bus.instruction[11:6]  = 6'($urandom_range(0, 7));
         bus.instruction[5:0]   = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 63))
                                                              : 6'($urandom_range(0, 7));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
